// File: rtl/sdram_burst_stream_engine.sv
// ---------------------------------------------------------------------------
// sdram_burst_stream_engine
//
// Read-modify-write client for a framebuffer region held in SDRAM.
// Each pass reads one burst into a readout FIFO and streams it to an external
// pixel processor. Processed words are collected in a writeback FIFO and
// written back to the same addresses. The engine then moves on to the next
// burst and wraps at the end of the region. It shares the SDRAM arbiter with
// the LCD scanout client and releases the bus whenever it is idle.
//
// Ports
//   i_Clk, i_Reset                 clock, synchronous active-high reset
//   i_Enable                       start new bursts (the current burst always completes)
//   i_SDRAM_Requested              other client wants the bus
//   o_SDRAM_Yield                  bus released (idle and requested)
//   o_Command / o_Data_Address     command and word address to the SDRAM controller
//   i_Data_Read_Valid/i_Data_Read  read beats from the controller
//   i_Data_Write_Done/o_Data_Write write beat consumed / writeback FIFO head
//   o_Px_Valid/o_Px_Data/i_Px_Ready   words out to the pixel processor
//   i_Res_Valid/i_Res_Data/o_Res_Ready processed words back from the processor
//   o_Frame_Done                   one-cycle pulse after the last burst of the region is written
// ---------------------------------------------------------------------------
module sdram_burst_stream_engine #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 22,
    parameter int BURST_LEN    = 8,
    parameter int FIFO_DEPTH   = 16,
    parameter int REGION_BASE  = 0,
    parameter int REGION_WORDS = 96000
) (
    input  logic              i_Clk,
    input  logic              i_Reset,
    input  logic              i_Enable,
    input  logic              i_SDRAM_Requested,
    output logic              o_SDRAM_Yield,
    output logic [1:0]        o_Command,
    output logic [ADDR_W-1:0] o_Data_Address,
    input  logic              i_Data_Read_Valid,
    input  logic [DATA_W-1:0] i_Data_Read,
    input  logic              i_Data_Write_Done,
    output logic [DATA_W-1:0] o_Data_Write,
    output logic              o_Px_Valid,
    output logic [DATA_W-1:0] o_Px_Data,
    input  logic              i_Px_Ready,
    input  logic              i_Res_Valid,
    input  logic [DATA_W-1:0] i_Res_Data,
    output logic              o_Res_Ready,
    output logic              o_Frame_Done
);

    // Controller command encodings (shared with the SDRAM controller).
    localparam logic [1:0] CMD_IDLE  = 2'd0;
    localparam logic [1:0] CMD_READ  = 2'd1;
    localparam logic [1:0] CMD_WRITE = 2'd2;

    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int BEAT_W = $clog2(BURST_LEN);

    localparam logic [CNT_W-1:0]  BURST_CNT  = CNT_W'(BURST_LEN);
    localparam logic [PTR_W-1:0]  PTR_LAST   = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [BEAT_W-1:0] BEAT_LAST  = BEAT_W'(BURST_LEN - 1);
    localparam logic [ADDR_W-1:0] BASE_ADDR  = ADDR_W'(REGION_BASE);
    localparam logic [ADDR_W-1:0] WRAP_ADDR  = ADDR_W'(REGION_BASE + REGION_WORDS - BURST_LEN);
    localparam logic [ADDR_W-1:0] BURST_STEP = ADDR_W'(BURST_LEN);

    typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_PROCESS, ST_WRITE} state_t;

    state_t state, state_next;

    logic [ADDR_W-1:0] burst_ptr;
    logic [ADDR_W-1:0] addr;
    logic [BEAT_W-1:0] beat;
    logic              frame_done;

    logic start_read, start_write, read_beat, write_beat;

    // Readout FIFO (SDRAM -> processor) and writeback FIFO (processor -> SDRAM).
    logic [DATA_W-1:0] rd_mem [FIFO_DEPTH];
    logic [DATA_W-1:0] wb_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_wr_ptr, rd_rd_ptr, wb_wr_ptr, wb_rd_ptr;
    logic [CNT_W-1:0]  rd_count, wb_count;
    logic              rd_push, rd_pop, wb_push, wb_pop;

    // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) state <= ST_IDLE;
        else         state <= state_next;
    end

    // NOTE: every output of this block is given a default first so no latch is inferred.
    always_comb begin
        state_next  = state;
        start_read  = 1'b0;
        start_write = 1'b0;
        read_beat   = 1'b0;
        write_beat  = 1'b0;
        o_Command   = CMD_IDLE;
        case (state)
            ST_IDLE: begin
                // A pending bus request beats both transitions; writeback beats a new read.
                if (!i_SDRAM_Requested) begin
                    if (wb_count >= BURST_CNT) begin
                        start_write = 1'b1;
                        state_next  = ST_WRITE;
                    end else if (i_Enable && rd_count == '0 && wb_count == '0) begin
                        start_read = 1'b1;
                        state_next = ST_READ;
                    end
                end
            end
            ST_READ: begin
                o_Command = CMD_READ;
                if (i_Data_Read_Valid) begin
                    read_beat = 1'b1;
                    if (beat == '0) state_next = ST_PROCESS;
                end
            end
            ST_PROCESS: begin
                // Bus is not held here; go back to IDLE so the arbiter can see a yield.
                if (wb_count >= BURST_CNT) state_next = ST_IDLE;
            end
            ST_WRITE: begin
                o_Command = CMD_WRITE;
                if (i_Data_Write_Done) begin
                    write_beat = 1'b1;
                    if (beat == '0) state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Address, beat counter and region walk.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            addr       <= BASE_ADDR;
            burst_ptr  <= BASE_ADDR;
            beat       <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (start_read || start_write) begin
                addr <= burst_ptr;
                beat <= BEAT_LAST;
            end else if (read_beat || write_beat) begin
                addr <= addr + ADDR_W'(1);
                beat <= beat - BEAT_W'(1);
            end
            if (write_beat && beat == '0) begin
                if (burst_ptr == WRAP_ADDR) begin
                    burst_ptr  <= BASE_ADDR;
                    frame_done <= 1'b1;
                end else begin
                    burst_ptr <= burst_ptr + BURST_STEP;
                end
            end
        end
    end

    assign rd_push = read_beat;
    assign rd_pop  = o_Px_Valid && i_Px_Ready;
    assign wb_push = i_Res_Valid && o_Res_Ready;
    assign wb_pop  = write_beat;

    // NOTE: FIFO storage has no reset; the flushed pointers and counts define emptiness,
    // so the arrays can map onto plain RAM.
    always_ff @(posedge i_Clk) begin
        if (rd_push) rd_mem[rd_wr_ptr] <= i_Data_Read;
        if (wb_push) wb_mem[wb_wr_ptr] <= i_Res_Data;
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            rd_wr_ptr <= '0;
            rd_rd_ptr <= '0;
            rd_count  <= '0;
            wb_wr_ptr <= '0;
            wb_rd_ptr <= '0;
            wb_count  <= '0;
        end else begin
            if (rd_push) rd_wr_ptr <= (rd_wr_ptr == PTR_LAST) ? '0 : rd_wr_ptr + PTR_W'(1);
            if (rd_pop)  rd_rd_ptr <= (rd_rd_ptr == PTR_LAST) ? '0 : rd_rd_ptr + PTR_W'(1);
            if (wb_push) wb_wr_ptr <= (wb_wr_ptr == PTR_LAST) ? '0 : wb_wr_ptr + PTR_W'(1);
            if (wb_pop)  wb_rd_ptr <= (wb_rd_ptr == PTR_LAST) ? '0 : wb_rd_ptr + PTR_W'(1);
            case ({rd_push, rd_pop})
                2'b10:   rd_count <= rd_count + CNT_W'(1);
                2'b01:   rd_count <= rd_count - CNT_W'(1);
                default: rd_count <= rd_count;
            endcase
            case ({wb_push, wb_pop})
                2'b10:   wb_count <= wb_count + CNT_W'(1);
                2'b01:   wb_count <= wb_count - CNT_W'(1);
                default: wb_count <= wb_count;
            endcase
        end
    end

    assign o_SDRAM_Yield  = i_SDRAM_Requested && (state == ST_IDLE);
    assign o_Data_Address = addr;
    assign o_Data_Write   = wb_mem[wb_rd_ptr];
    assign o_Px_Valid     = (state == ST_PROCESS) && (rd_count != '0);
    assign o_Px_Data      = rd_mem[rd_rd_ptr];
    // Capping at one burst keeps results for the next burst out until WRITE drains this one.
    assign o_Res_Ready    = (wb_count < BURST_CNT);
    assign o_Frame_Done   = frame_done;

endmodule
